// File: rtl/branch_target_predictor.sv
// Branch target buffer with per-entry 2-bit saturating direction counters.
// Lookup is combinational from the IF-stage PC. Update is registered from
// the resolved branch. Two saturating counters track how many updates were
// accepted and how many of them were mispredicts.
module branch_target_predictor #(
  parameter int WORD_SIZE = 16,
  parameter int ENTRIES   = 16,
  parameter int STAT_W    = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 lookup_valid,
  input  logic [WORD_SIZE-1:0] lookup_pc,
  output logic                 pred_hit,
  output logic                 pred_taken,
  output logic [WORD_SIZE-1:0] pred_target,
  input  logic                 update_valid,
  input  logic [WORD_SIZE-1:0] update_pc,
  input  logic                 update_taken,
  input  logic [WORD_SIZE-1:0] update_target,
  input  logic                 update_uncond,
  input  logic                 update_mispredict,
  input  logic                 flush,
  output logic [STAT_W-1:0]    update_count,
  output logic [STAT_W-1:0]    mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = WORD_SIZE - IDX_W;

  logic                 valid_mem  [ENTRIES];
  logic [TAG_W-1:0]     tag_mem    [ENTRIES];
  logic [WORD_SIZE-1:0] target_mem [ENTRIES];
  logic                 uncond_mem [ENTRIES];
  logic [1:0]           ctr_mem    [ENTRIES];

  logic [IDX_W-1:0] lookup_idx;
  logic [TAG_W-1:0] lookup_tag;
  logic [IDX_W-1:0] update_idx;
  logic [TAG_W-1:0] update_tag;
  logic             update_hit;

  assign lookup_idx = lookup_pc[IDX_W-1:0];
  assign lookup_tag = lookup_pc[WORD_SIZE-1:IDX_W];
  assign update_idx = update_pc[IDX_W-1:0];
  assign update_tag = update_pc[WORD_SIZE-1:IDX_W];
  assign update_hit = valid_mem[update_idx] && (tag_mem[update_idx] == update_tag);

  // Zero-latency prediction from the pre-update table contents
  always_comb begin
    pred_hit    = lookup_valid && valid_mem[lookup_idx] && (tag_mem[lookup_idx] == lookup_tag);
    pred_taken  = pred_hit && (uncond_mem[lookup_idx] || ctr_mem[lookup_idx][1]);
    pred_target = pred_taken ? target_mem[lookup_idx] : (lookup_pc + WORD_SIZE'(1));
  end

  // Table maintenance: reset, flush (wins over update), then train or allocate
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_mem[i]  <= 1'b0;
        tag_mem[i]    <= '0;
        target_mem[i] <= '0;
        uncond_mem[i] <= 1'b0;
        ctr_mem[i]    <= 2'b01;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_mem[i] <= 1'b0;
      end
    end else if (update_valid) begin
      if (update_hit) begin
        if (update_uncond) begin
          ctr_mem[update_idx] <= 2'b11;
        end else if (update_taken) begin
          if (ctr_mem[update_idx] != 2'b11) ctr_mem[update_idx] <= ctr_mem[update_idx] + 2'd1;
        end else begin
          if (ctr_mem[update_idx] != 2'b00) ctr_mem[update_idx] <= ctr_mem[update_idx] - 2'd1;
        end
        if (update_taken) target_mem[update_idx] <= update_target;
        uncond_mem[update_idx] <= update_uncond;
      end else if (update_taken) begin
        valid_mem[update_idx]  <= 1'b1;
        tag_mem[update_idx]    <= update_tag;
        target_mem[update_idx] <= update_target;
        uncond_mem[update_idx] <= update_uncond;
        ctr_mem[update_idx]    <= update_uncond ? 2'b11 : 2'b10;
      end
    end
  end

  // Saturating statistics; counted even when a flush discards the update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      update_count     <= '0;
      mispredict_count <= '0;
    end else if (update_valid) begin
      if (update_count != '1) update_count <= update_count + STAT_W'(1);
      if (update_mispredict && (mispredict_count != '1)) mispredict_count <= mispredict_count + STAT_W'(1);
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed testbench for branch_target_predictor: a default 16-bit/16-entry
// instance and a 12-bit/4-entry instance, each with hand-computed results.
module tb_branch_target_predictor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vec_count  = 0;
  int fail_count = 0;

  // 16-bit, 16-entry instance
  logic        a_reset_n, a_lookup_valid, a_update_valid, a_update_taken;
  logic        a_update_uncond, a_update_mispredict, a_flush;
  logic        a_pred_hit, a_pred_taken;
  logic [15:0] a_lookup_pc, a_pred_target, a_update_pc, a_update_target;
  logic [15:0] a_update_count, a_mispredict_count;

  // 12-bit, 4-entry instance
  logic        b_reset_n, b_lookup_valid, b_update_valid, b_update_taken;
  logic        b_update_uncond, b_update_mispredict, b_flush;
  logic        b_pred_hit, b_pred_taken;
  logic [11:0] b_lookup_pc, b_pred_target, b_update_pc, b_update_target;
  logic [15:0] b_update_count, b_mispredict_count;

  branch_target_predictor #(.WORD_SIZE(16), .ENTRIES(16), .STAT_W(16)) dut_a (
    .clk(clk), .reset_n(a_reset_n),
    .lookup_valid(a_lookup_valid), .lookup_pc(a_lookup_pc),
    .pred_hit(a_pred_hit), .pred_taken(a_pred_taken), .pred_target(a_pred_target),
    .update_valid(a_update_valid), .update_pc(a_update_pc), .update_taken(a_update_taken),
    .update_target(a_update_target), .update_uncond(a_update_uncond),
    .update_mispredict(a_update_mispredict), .flush(a_flush),
    .update_count(a_update_count), .mispredict_count(a_mispredict_count)
  );

  branch_target_predictor #(.WORD_SIZE(12), .ENTRIES(4), .STAT_W(16)) dut_b (
    .clk(clk), .reset_n(b_reset_n),
    .lookup_valid(b_lookup_valid), .lookup_pc(b_lookup_pc),
    .pred_hit(b_pred_hit), .pred_taken(b_pred_taken), .pred_target(b_pred_target),
    .update_valid(b_update_valid), .update_pc(b_update_pc), .update_taken(b_update_taken),
    .update_target(b_update_target), .update_uncond(b_update_uncond),
    .update_mispredict(b_update_mispredict), .flush(b_flush),
    .update_count(b_update_count), .mispredict_count(b_mispredict_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vec_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One update on instance A across one rising edge
  task automatic applyStimulus(input logic [15:0] pc, input logic taken, input logic [15:0] tgt,
                               input logic uncond, input logic mis);
    a_update_valid = 1'b1; a_update_pc = pc; a_update_taken = taken;
    a_update_target = tgt; a_update_uncond = uncond; a_update_mispredict = mis;
    @(posedge clk); #1;
    a_update_valid = 1'b0; a_update_mispredict = 1'b0;
  endtask

  task automatic applyStimulusSmall(input logic [11:0] pc, input logic taken, input logic [11:0] tgt,
                                    input logic uncond, input logic mis);
    b_update_valid = 1'b1; b_update_pc = pc; b_update_taken = taken;
    b_update_target = tgt; b_update_uncond = uncond; b_update_mispredict = mis;
    @(posedge clk); #1;
    b_update_valid = 1'b0; b_update_mispredict = 1'b0;
  endtask

  task automatic lookA(input string tag, input logic [15:0] pc, input logic hit, input logic tk, input logic [15:0] tgt);
    a_lookup_pc = pc; #1;
    checkOutput({tag, "_hit"}, 32'(a_pred_hit), 32'(hit));
    checkOutput({tag, "_taken"}, 32'(a_pred_taken), 32'(tk));
    checkOutput({tag, "_target"}, 32'(a_pred_target), 32'(tgt));
  endtask

  task automatic lookB(input string tag, input logic [11:0] pc, input logic hit, input logic tk, input logic [11:0] tgt);
    b_lookup_pc = pc; #1;
    checkOutput({tag, "_hit"}, 32'(b_pred_hit), 32'(hit));
    checkOutput({tag, "_taken"}, 32'(b_pred_taken), 32'(tk));
    checkOutput({tag, "_target"}, 32'(b_pred_target), 32'(tgt));
  endtask

  initial begin
    a_reset_n = 1'b0; a_lookup_valid = 1'b1; a_lookup_pc = 16'h0040;
    a_update_valid = 1'b0; a_update_pc = '0; a_update_taken = 1'b0; a_update_target = '0;
    a_update_uncond = 1'b0; a_update_mispredict = 1'b0; a_flush = 1'b0;
    b_reset_n = 1'b0; b_lookup_valid = 1'b1; b_lookup_pc = 12'h040;
    b_update_valid = 1'b0; b_update_pc = '0; b_update_taken = 1'b0; b_update_target = '0;
    b_update_uncond = 1'b0; b_update_mispredict = 1'b0; b_flush = 1'b0;

    // Reset state
    @(posedge clk); #1;
    lookA("a_rst", 16'h0040, 1'b0, 1'b0, 16'h0041);
    checkOutput("a_rst_ucnt", 32'(a_update_count), 32'd0);
    checkOutput("a_rst_mcnt", 32'(a_mispredict_count), 32'd0);
    a_reset_n = 1'b1; b_reset_n = 1'b1;
    @(posedge clk); #1;
    lookA("a_wrap", 16'hFFFF, 1'b0, 1'b0, 16'h0000);

    // Allocate 0x0043; a same-cycle lookup must still miss
    a_update_valid = 1'b1; a_update_pc = 16'h0043; a_update_taken = 1'b1;
    a_update_target = 16'h0010; a_update_uncond = 1'b0; a_update_mispredict = 1'b1;
    a_lookup_pc = 16'h0043; #1;
    checkOutput("a_nobypass_hit", 32'(a_pred_hit), 32'd0);
    @(posedge clk); #1;
    a_update_valid = 1'b0; a_update_mispredict = 1'b0;
    lookA("a_alloc", 16'h0043, 1'b1, 1'b1, 16'h0010);
    lookA("a_tagmiss", 16'h0053, 1'b0, 1'b0, 16'h0054);
    a_lookup_valid = 1'b0; a_lookup_pc = 16'h0043; #1;
    checkOutput("a_lkinv_hit", 32'(a_pred_hit), 32'd0);
    a_lookup_valid = 1'b1;

    // Counter training: 10 -> 01 -> 00, then up to saturation at 11
    applyStimulus(16'h0043, 1'b0, 16'h0999, 1'b0, 1'b0);
    lookA("a_ctr01", 16'h0043, 1'b1, 1'b0, 16'h0044);
    applyStimulus(16'h0043, 1'b0, 16'h0999, 1'b0, 1'b0);
    lookA("a_ctr00", 16'h0043, 1'b1, 1'b0, 16'h0044);
    applyStimulus(16'h0043, 1'b1, 16'h0020, 1'b0, 1'b0);
    lookA("a_ctrup01", 16'h0043, 1'b1, 1'b0, 16'h0044);
    applyStimulus(16'h0043, 1'b1, 16'h0020, 1'b0, 1'b0);
    lookA("a_ctrup10", 16'h0043, 1'b1, 1'b1, 16'h0020);
    applyStimulus(16'h0043, 1'b1, 16'h0020, 1'b0, 1'b0);
    applyStimulus(16'h0043, 1'b0, 16'h0999, 1'b0, 1'b0);
    lookA("a_ctrsat", 16'h0043, 1'b1, 1'b1, 16'h0020);
    checkOutput("a_ucnt7", 32'(a_update_count), 32'd7);
    checkOutput("a_mcnt1", 32'(a_mispredict_count), 32'd1);

    // Not-taken miss must not allocate
    applyStimulus(16'h0077, 1'b0, 16'h0123, 1'b0, 1'b0);
    lookA("a_ntmiss", 16'h0077, 1'b0, 1'b0, 16'h0078);

    // Unconditional jump stays taken
    applyStimulus(16'h0100, 1'b1, 16'h0200, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      lookA("a_uncond", 16'h0100, 1'b1, 1'b1, 16'h0200);
      @(posedge clk); #1;
    end

    // update_valid low changes nothing, mispredict alone ignored
    a_update_pc = 16'h0043; a_update_taken = 1'b1; a_update_target = 16'h0ABC;
    a_update_mispredict = 1'b1;
    @(posedge clk); #1;
    a_update_mispredict = 1'b0;
    lookA("a_noupd", 16'h0043, 1'b1, 1'b1, 16'h0020);
    checkOutput("a_ucnt9", 32'(a_update_count), 32'd9);
    checkOutput("a_mcnt1b", 32'(a_mispredict_count), 32'd1);

    // Flush wins over a simultaneous update, which is still counted
    a_flush = 1'b1;
    applyStimulus(16'h0200, 1'b1, 16'h0300, 1'b0, 1'b1);
    a_flush = 1'b0;
    lookA("a_flush100", 16'h0100, 1'b0, 1'b0, 16'h0101);
    lookA("a_flush200", 16'h0200, 1'b0, 1'b0, 16'h0201);
    checkOutput("a_ucnt10", 32'(a_update_count), 32'd10);
    checkOutput("a_mcnt2", 32'(a_mispredict_count), 32'd2);

    // Statistics saturation
    a_update_valid = 1'b1; a_update_pc = 16'h0005; a_update_taken = 1'b0;
    a_update_uncond = 1'b0; a_update_mispredict = 1'b1;
    repeat (65539) @(posedge clk);
    #1;
    a_update_valid = 1'b0; a_update_mispredict = 1'b0;
    checkOutput("a_ucnt_sat", 32'(a_update_count), 32'hFFFF);
    checkOutput("a_mcnt_sat", 32'(a_mispredict_count), 32'hFFFF);

    // Narrow instance: same directed sequence
    lookB("b_rst", 12'h040, 1'b0, 1'b0, 12'h041);
    lookB("b_wrap", 12'hFFF, 1'b0, 1'b0, 12'h000);
    applyStimulusSmall(12'h043, 1'b1, 12'h010, 1'b0, 1'b1);
    lookB("b_alloc", 12'h043, 1'b1, 1'b1, 12'h010);
    lookB("b_tagmiss", 12'h053, 1'b0, 1'b0, 12'h054);
    applyStimulusSmall(12'h043, 1'b0, 12'h999, 1'b0, 1'b0);
    applyStimulusSmall(12'h043, 1'b0, 12'h999, 1'b0, 1'b0);
    lookB("b_ctr00", 12'h043, 1'b1, 1'b0, 12'h044);
    applyStimulusSmall(12'h043, 1'b1, 12'h030, 1'b0, 1'b0);
    applyStimulusSmall(12'h043, 1'b1, 12'h030, 1'b0, 1'b0);
    applyStimulusSmall(12'h043, 1'b1, 12'h030, 1'b0, 1'b0);
    applyStimulusSmall(12'h043, 1'b0, 12'h999, 1'b0, 1'b0);
    lookB("b_ctrsat", 12'h043, 1'b1, 1'b1, 12'h030);
    checkOutput("b_ucnt7", 32'(b_update_count), 32'd7);
    checkOutput("b_mcnt1", 32'(b_mispredict_count), 32'd1);

    // Reset asserted in the middle of an update plus flush
    b_update_valid = 1'b1; b_update_pc = 12'h081; b_update_taken = 1'b1;
    b_update_target = 12'h022; b_update_uncond = 1'b0; b_update_mispredict = 1'b1; b_flush = 1'b1;
    #1 b_reset_n = 1'b0;
    lookB("b_inrst", 12'h043, 1'b0, 1'b0, 12'h044);
    checkOutput("b_inrst_ucnt", 32'(b_update_count), 32'd0);
    @(posedge clk); #1;
    b_update_valid = 1'b0; b_update_mispredict = 1'b0; b_flush = 1'b0;
    b_reset_n = 1'b1;
    @(posedge clk); #1;
    lookB("b_post081", 12'h081, 1'b0, 1'b0, 12'h082);
    lookB("b_post043", 12'h043, 1'b0, 1'b0, 12'h044);
    checkOutput("b_post_ucnt", 32'(b_update_count), 32'd0);
    checkOutput("b_post_mcnt", 32'(b_mispredict_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
    $finish;
  end

endmodule

// File: doc/branch_target_predictor.md
BRANCH_TARGET_PREDICTOR -- requirements
Module: branch_target_predictor

Interface
REQ-001 Parameter WORD_SIZE, 16, PC/target width in bits; SHALL be greater than IDX_W.
REQ-002 Parameter ENTRIES, 16, BTB entry count; SHALL be a power of two, at least 2; IDX_W = log2(ENTRIES), TAG_W = WORD_SIZE - IDX_W.
REQ-003 Parameter STAT_W, 16, width of statistics counters.
REQ-004 Port clk  input  1  clock; all state changes on rising edge.
REQ-005 Port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 Port lookup_valid  input  1  IF-stage lookup request.
REQ-007 Port lookup_pc  input  WORD_SIZE  PC being fetched.
REQ-008 Port pred_hit  output  1  lookup found a valid, tag-matching entry.
REQ-009 Port pred_taken  output  1  predict redirect.
REQ-010 Port pred_target  output  WORD_SIZE  predicted next PC.
REQ-011 Port update_valid  input  1  resolved branch/jump reported this cycle.
REQ-012 Port update_pc  input  WORD_SIZE  PC of resolved instruction.
REQ-013 Port update_taken  input  1  actual outcome.
REQ-014 Port update_target  input  WORD_SIZE  actual taken target.
REQ-015 Port update_uncond  input  1  instruction is JMP/JAL/JPR/JRL (always taken).
REQ-016 Port update_mispredict  input  1  pipeline flushed for this instruction.
REQ-017 Port flush  input  1  synchronous invalidate of all entries.
REQ-018 Port update_count  output  STAT_W  number of accepted updates.
REQ-019 Port mispredict_count  output  STAT_W  number of mispredicts.

Function
REQ-020 Per entry storage SHALL be: valid, tag[TAG_W], target[WORD_SIZE], uncond, 2-bit saturating counter ctr.
REQ-021 Index SHALL be pc[IDX_W-1:0]; tag SHALL be pc[WORD_SIZE-1:IDX_W].
REQ-022 Lookup SHALL be purely combinational, zero-cycle latency: pred_hit = lookup_valid & valid[idx] & (tag[idx] == lookup tag).
REQ-023 pred_taken SHALL be pred_hit & (uncond[idx] | ctr[idx][1]).
REQ-024 pred_target SHALL be target[idx] when pred_taken, else lookup_pc + 1 modulo 2^WORD_SIZE (0xFFFF+1 wraps to 0x0000).
REQ-025 Update SHALL act on the rising edge when update_valid=1; update_valid=0 SHALL change no entry.
REQ-026 Update hit (valid and tag match at update index): ctr increments on taken, decrements on not-taken, saturating at 2'b11 and 2'b00; target overwritten only when update_taken=1; uncond overwritten with update_uncond.
REQ-027 Update with update_uncond=1 SHALL force ctr to 2'b11 on hit or allocate.
REQ-028 Update miss with update_taken=1 SHALL allocate (overwrite) the indexed entry: valid=1, tag, target, uncond, ctr=2'b10 (2'b11 if uncond).
REQ-029 Update miss with update_taken=0 SHALL not allocate or modify the entry.
REQ-030 Lookup and update in the same cycle SHALL see pre-update state; no bypass.
REQ-031 flush=1 SHALL clear all valid bits at the edge; flush SHALL take priority over a simultaneous update (update discarded, still counted in statistics).
REQ-032 update_count SHALL increment on every update_valid=1 edge; mispredict_count SHALL increment when update_valid & update_mispredict; both SHALL saturate at all-ones.
REQ-033 update_mispredict without update_valid SHALL be ignored.

Reset
REQ-034 reset_n low SHALL immediately clear all valid bits, set every ctr to 2'b01, uncond to 0, target and tag to 0, and both statistics counters to 0.
REQ-035 During and after reset, pred_hit=0, pred_taken=0, pred_target=lookup_pc+1 until an allocating update.
REQ-036 Reset asserted mid-operation SHALL override any same-cycle update or flush.

Verification
REQ-037 After reset, lookup_pc=0x0040 -> pred_hit=0, pred_taken=0, pred_target=0x0041.
REQ-038 Update pc=0x0043 taken target=0x0010 cond; next cycle lookup 0x0043 -> hit=1, taken=1, target=0x0010; lookup 0x0053 (same index, different tag) -> hit=0.
REQ-039 Same entry: two not-taken updates -> ctr 10->01->00, lookup taken=0 and target=0x0044; three taken updates -> ctr saturates at 11, taken=1.
REQ-040 Update pc=0x0100 uncond target=0x0200 then ten not-taken-cond-free lookups -> taken=1 always; flush plus same-cycle update -> hit=0 next cycle, update_count still increments.
REQ-041 Drive 2^STAT_W+3 updates with update_mispredict=1 -> both counters hold 0xFFFF (STAT_W=16).
REQ-042 Re-run REQ-037..039 with WORD_SIZE=12, ENTRIES=4; assert reset_n mid-update -> all lookups miss, counters 0.
